// File: rtl/hwpe_stream_addressgen_sched_if.sv
// rtl/hwpe_stream_addressgen_sched_if.sv - TCDM, address generator and stream credit signals
// The scheduler drives the master side; the TCDM port, address generator and stream FIFO sit on the slave side.
interface hwpe_stream_addressgen_sched_if;
   logic addrgen_clear;
   logic addrgen_enable;
   logic tcdm_req;
   logic tcdm_gnt;
   logic stream_hs;

   modport master (
      output addrgen_clear,
      output addrgen_enable,
      output tcdm_req,
      input  tcdm_gnt,
      input  stream_hs
   );

   modport slave (
      input  addrgen_clear,
      input  addrgen_enable,
      input  tcdm_req,
      output tcdm_gnt,
      output stream_hs
   );
endinterface

// File: rtl/hwpe_stream_addressgen_sched.sv
// rtl/hwpe_stream_addressgen_sched.sv - credit-throttled load sequencer for one address generator
// Clears the generator, issues trans_size TCDM requests and finishes once every loaded word has been consumed downstream.
module hwpe_stream_addressgen_sched #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned CNT             = 16
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   clear_i,
   input  logic                                   start_i,
   input  logic [CNT-1:0]                         trans_size_i,
   hwpe_stream_addressgen_sched_if.master         bus,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   credits_o
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CR_MAX = CW'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [CNT-1:0] size_q, size_d;
   logic [CNT-1:0] issued_q, issued_d;
   logic [CNT-1:0] consumed_q, consumed_d;
   logic [CW-1:0]  credits_q, credits_d;

   logic active;
   logic req;
   logic gnt_acc;
   logic hs_ok;

   assign active  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   // Request depends on registered state only, never on the same-cycle grant.
   assign req     = (state_q == S_ISSUE) && (credits_q != '0) && (issued_q < size_q);
   assign gnt_acc = req & bus.tcdm_gnt;
   assign hs_ok   = active && bus.stream_hs && (credits_q != CR_MAX);

   always_comb begin
      state_d    = state_q;
      size_d     = size_q;
      issued_d   = issued_q;
      consumed_d = consumed_q;
      credits_d  = credits_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               size_d  = trans_size_i;
               state_d = (trans_size_i != '0) ? S_CLEAR : S_DONE;
            end
         end
         S_CLEAR: begin
            issued_d   = '0;
            consumed_d = '0;
            credits_d  = CR_MAX;
            state_d    = S_ISSUE;
         end
         S_ISSUE, S_DRAIN: begin
            if (gnt_acc) issued_d = issued_q + CNT'(1);
            if (hs_ok && (consumed_q != size_q)) consumed_d = consumed_q + CNT'(1);
            case ({gnt_acc, hs_ok})
               2'b10:   credits_d = credits_q - CW'(1);
               2'b01:   credits_d = credits_q + CW'(1);
               default: credits_d = credits_q;
            endcase
            if (state_q == S_ISSUE) begin
               if (gnt_acc && (issued_d == size_q)) state_d = S_DRAIN;
            end else if (consumed_d == size_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Soft clear drops any outstanding grants and wins over a same-cycle start.
      if (clear_i) begin
         state_d    = S_IDLE;
         size_d     = '0;
         issued_d   = '0;
         consumed_d = '0;
         credits_d  = CR_MAX;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         size_q     <= '0;
         issued_q   <= '0;
         consumed_q <= '0;
         credits_q  <= CR_MAX;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         issued_q   <= issued_d;
         consumed_q <= consumed_d;
         credits_q  <= credits_d;
      end
   end

   assign bus.tcdm_req       = req;
   assign bus.addrgen_enable = gnt_acc;
   assign bus.addrgen_clear  = (state_q == S_CLEAR) || clear_i;
   assign busy_o             = (state_q != S_IDLE);
   assign done_o             = (state_q == S_DONE);
   assign credits_o          = credits_q;

   // A stream handshake with no word in flight is ignored by the logic above and flagged here.
   a_hs_legal: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
                                bus.stream_hs |-> hs_ok);

endmodule

// File: tb/tb_hwpe_stream_addressgen_sched.sv
// tb/tb_hwpe_stream_addressgen_sched.sv - directed self-checking bench for hwpe_stream_addressgen_sched
module tb_hwpe_stream_addressgen_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        start;
    logic [15:0] tsize;
    wire         busy;
    wire         done;
    wire  [2:0]  credits;

    int n_checks = 0;
    int n_fail   = 0;

    hwpe_stream_addressgen_sched_if bus ();

    hwpe_stream_addressgen_sched #(
        .MAX_OUTSTANDING (4),
        .CNT             (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .start_i      (start),
        .trans_size_i (tsize),
        .bus          (bus),
        .busy_o       (busy),
        .done_o       (done),
        .credits_o    (credits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer; hs returns one credit per word granted in an earlier cycle, held off for hs_hold cycles.
    task automatic xfer(input string tag, input int size, input int gnt_pct, input int hs_hold,
                        output int n_en, output int n_clr,
                        output int snap_grants, output int snap_cr, output int snap_req);
        int   pending;
        int   first_req;
        int   last_hs;
        int   done_k;
        int   errs;
        logic g;
        logic h;
        logic r0;
        n_en = 0; n_clr = 0; pending = 0; first_req = -1; last_hs = -1; done_k = -1; errs = 0;
        snap_grants = -1; snap_cr = -1; snap_req = -1;
        start = 1'b1;
        tsize = 16'(size);
        step();
        start = 1'b0;
        tsize = 16'hFFFF;
        for (int k = 0; k < 300 && done_k < 0; k++) begin
            if (k > 0) step();
            g = ($urandom_range(99) < gnt_pct);
            h = (pending > 0) && (k >= hs_hold);
            bus.tcdm_gnt  = 1'b0;
            bus.stream_hs = h;
            #1;
            r0 = bus.tcdm_req;
            bus.tcdm_gnt = g;
            #1;
            if (bus.tcdm_req !== r0) errs++;
            if (bus.addrgen_enable !== (r0 & g)) errs++;
            if (credits !== 3'(4 - pending)) errs++;
            if (bus.addrgen_clear) n_clr++;
            if (r0 && first_req < 0) first_req = k;
            if (k == hs_hold) begin
                snap_grants = n_en;
                snap_cr     = int'(credits);
                snap_req    = int'(r0);
            end
            if (done) done_k = k;
            if (h) begin
                pending--;
                last_hs = k;
            end
            if (bus.addrgen_enable) begin
                n_en++;
                pending++;
            end
        end
        bus.tcdm_gnt  = 1'b0;
        bus.stream_hs = 1'b0;
        check({tag, "_done_seen"}, done_k >= 0, 1);
        check({tag, "_per_cycle"}, errs, 0);
        if (size > 0) begin
            check({tag, "_first_req_lat"}, first_req, 1);
            check({tag, "_done_lat"}, done_k, last_hs + 1);
        end else begin
            check({tag, "_done_lat"}, done_k, 0);
            check({tag, "_no_req"}, first_req, -1);
        end
        step();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_credits"}, credits, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en, clr, sg, sc, sr, cnt;
        rst = 1'b1; clear = 1'b0; start = 1'b0; tsize = '0;
        bus.tcdm_gnt = 1'b0; bus.stream_hs = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_req", bus.tcdm_req, 0);
        check("rst_enable", bus.addrgen_enable, 0);
        check("rst_clear", bus.addrgen_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_credits", credits, 4);

        xfer("t1", 8, 100, 0, en, clr, sg, sc, sr);
        check("t1_enables", en, 8);
        check("t1_clears", clr, 1);

        xfer("t2", 6, 100, 20, en, clr, sg, sc, sr);
        check("t2_stall_grants", sg, 4);
        check("t2_stall_credits", sc, 0);
        check("t2_stall_req", sr, 0);
        check("t2_enables", en, 6);

        xfer("t3", 5, 30, 0, en, clr, sg, sc, sr);
        check("t3_enables", en, 5);

        xfer("t4a", 0, 100, 0, en, clr, sg, sc, sr);
        check("t4a_enables", en, 0);
        check("t4a_clears", clr, 0);
        xfer("t4b", 1, 100, 0, en, clr, sg, sc, sr);
        check("t4b_enables", en, 1);

        // T5: soft clear mid-issue after three grants
        start = 1'b1; tsize = 16'd10;
        step();
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 3; k++) begin
            step();
            bus.tcdm_gnt = 1'b1;
            #1;
            if (bus.addrgen_enable) cnt++;
        end
        check("t5_grants", cnt, 3);
        step();
        clear = 1'b1; start = 1'b1; bus.tcdm_gnt = 1'b0;
        #1;
        check("t5_clear_comb", bus.addrgen_clear, 1);
        step();
        clear = 1'b0; start = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_credits", credits, 4);
        check("t5_req", bus.tcdm_req, 0);
        step();
        check("t5_start_lost", busy, 0);
        xfer("t5b", 2, 100, 0, en, clr, sg, sc, sr);
        check("t5b_enables", en, 2);

        // T6: reset in DRAIN
        start = 1'b1; tsize = 16'd2;
        step();
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 2; k++) begin
            step();
            bus.tcdm_gnt = 1'b1;
            #1;
            if (bus.addrgen_enable) cnt++;
        end
        step();
        bus.tcdm_gnt = 1'b0;
        #1;
        check("t6_drain_busy", busy, 1);
        check("t6_drain_req", bus.tcdm_req, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_req", bus.tcdm_req, 0);
        check("t6_rst_enable", bus.addrgen_enable, 0);
        check("t6_rst_clear", bus.addrgen_clear, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_credits", credits, 4);

        // T6: simultaneous grant and handshake at two credits
        start = 1'b1; tsize = 16'd6;
        step();
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 2; k++) begin
            step();
            bus.tcdm_gnt = 1'b1;
            #1;
            if (bus.addrgen_enable) cnt++;
        end
        step();
        check("t6_pre_credits", credits, 2);
        bus.tcdm_gnt = 1'b1; bus.stream_hs = 1'b1;
        #1;
        check("t6_both_enable", bus.addrgen_enable, 1);
        step();
        bus.tcdm_gnt = 1'b0; bus.stream_hs = 1'b0;
        check("t6_both_credits", credits, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
